delay_line_sink: RTL
====================

// Module: delay_line_sink
//
// PURPOSE
//   Receiving end of the fixed-latency delay line: accepts the valid-qualified
//   stream it emits (i_data/i_valid) and buffers it in a DEPTH-entry circular
//   FIFO. Downstream logic drains it through a ready/valid handshake.
//   Upstream has no backpressure, so words that arrive when the FIFO is full
//   are dropped and flagged.
//
// PARAMETERS
//   WIDTH   8   data word width in bits
//   DEPTH   4   FIFO entries; any value >= 2 (need not be a power of two)
//
// PORTS
//   clk         in   1                   single clock, all logic on posedge
//   rst_n       in   1                   synchronous, active-low reset
//   i_data      in   WIDTH               incoming word from delay line
//   i_valid     in   1                   i_data valid this cycle
//   o_data      out  WIDTH               head-of-FIFO word
//   o_valid     out  1                   o_data valid
//   i_ready     in   1                   consumer accepts o_data this cycle
//   o_count     out  $clog2(DEPTH)+1     number of stored entries, 0..DEPTH
//   o_overflow  out  1                   sticky: a word was dropped
//
// BEHAVIOUR
//   - Reset (rst_n==0 at posedge): wr_ptr=rd_ptr=0, o_count=0, o_overflow=0,
//     all mem entries 0; so o_valid=0 and o_data=0. Reset wins over any
//     concurrent push/pop. Mid-stream reset discards all contents.
//   - push = i_valid && (o_count<DEPTH || pop); pop = o_valid && i_ready.
//   - push: mem[wr_ptr]<=i_data; wr_ptr advances, wraps DEPTH-1 -> 0.
//   - pop: rd_ptr advances, wraps DEPTH-1 -> 0.
//   - o_count: +1 on push only, -1 on pop only, unchanged on both/neither.
//   - o_valid = (o_count!=0); o_data = mem[rd_ptr] (combinational read).
//   - Latency (no bypass): word pushed at edge N is visible on o_data and
//     o_valid after edge N; it can be popped at edge N+1 at the earliest.
//   - Full (o_count==DEPTH) with i_valid and pop: the word is accepted and
//     o_count stays DEPTH. Full with i_valid and no pop: the word is dropped,
//     o_overflow<=1 and stays 1 until reset. Pointers and count do not change.
//   - Empty with i_ready=1: no pop occurs; o_count never underflows.
//   - o_data is held stable while o_valid=1 and i_ready=0.
//
// CONFIGURATION
//   DELAY_LINE_SINK_BYPASS_EN defined: when o_count==0 and i_valid=1, then
//     o_valid=1 and o_data=i_data combinationally.
//     - If i_ready=1 as well, the word is consumed directly and is not
//       stored; o_count stays 0.
//     - If i_ready=0, the word is pushed normally.
//     - All other rules are unchanged.
//   Not defined: o_valid depends only on o_count (no input->output
//     combinational path); the minimum latency is one cycle.
//
// TESTING
//   1. Reset: hold rst_n=0 3 cycles with i_valid=1, i_data=8'hAA
//      -> o_valid=0, o_count=0, o_overflow=0, o_data=0.
//   2. Push 8'h11,22,33 on consecutive cycles with i_ready=0
//      -> o_count=3, o_data=8'h11. Then i_ready=1: pops 11,22,33 in order,
//      o_valid=0 after the third pop.
//   3. DEPTH=4: push 5 words 01..05 with i_ready=0 -> o_count=4,
//      o_overflow=1, reads return 01..04. Word 05 is lost.
//   4. Full FIFO, i_valid=1 (8'h55) and i_ready=1 together -> o_count stays
//      4, o_overflow stays 0, 8'h55 is read out last.
//   5. DEPTH=3 wrap: 10 push/pop cycles of a continuous stream 0..9 with
//      i_ready=1 -> output sequence 0..9 in order, pointers wrap cleanly.
//   6. Assert rst_n=0 with o_count=2 and o_overflow=1 -> next cycle
//      o_count=0, o_overflow=0. Bypass build: empty FIFO, i_valid=1,
//      i_data=8'h7E, i_ready=1 -> o_valid=1 and o_data=8'h7E in the same
//      cycle, o_count remains 0.

Source files
------------

// File: rtl/delay_line_sink.sv
// Receive-side FIFO for the fixed-latency delay line: buffers a valid-qualified stream
// with no upstream backpressure. Optional macro DELAY_LINE_SINK_BYPASS_EN adds an empty-FIFO bypass.
module delay_line_sink #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_valid,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             full, empty, bypass, pop_mem, take, push, drop;

    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
`ifdef DELAY_LINE_SINK_BYPASS_EN
        bypass  = empty && i_valid;
`else
        bypass  = 1'b0;
`endif
        // pop_mem only ever touches stored entries; a bypassed word never enters mem
        pop_mem = !empty && i_ready;
        take    = bypass && i_ready;
        push    = i_valid && !take && (!full || pop_mem);
        drop    = i_valid && full && !pop_mem;
    end

`ifdef DELAY_LINE_SINK_BYPASS_EN
    assign o_valid = !empty || bypass;
    assign o_data  = bypass ? i_data : mem[rd_ptr];
`else
    assign o_valid = !empty;
    assign o_data  = mem[rd_ptr];
`endif
    assign o_count    = count;
    assign o_overflow = overflow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= i_data;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_mem)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop_mem})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end
endmodule
